// File: rtl/layer_priority_mux_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// layer_priority_mux_if : pixel-layer bus between object drawers and the mux
// Revision: 1.0
// ---------------------------------------------------------------------------
interface layer_priority_mux_if #(
  parameter int N_CH  = 3,
  parameter int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1
);
  logic                startOfFrame;
  logic [N_CH-1:0]     drawReq;
  logic [8*N_CH-1:0]   rgbIn;
  logic [N_CH-1:0]     layerEnable;
  logic [N_CH-1:0]     blinkMask;
  logic                fadeStart;
  logic [7:0]          RGBOut;
  logic                anyDR;
  logic [IDX_W-1:0]    winnerIdx;

  modport master (
    output startOfFrame, drawReq, rgbIn, layerEnable, blinkMask, fadeStart,
    input  RGBOut, anyDR, winnerIdx
  );

  modport slave (
    input  startOfFrame, drawReq, rgbIn, layerEnable, blinkMask, fadeStart,
    output RGBOut, anyDR, winnerIdx
  );
endinterface
`default_nettype wire

// File: rtl/layer_priority_mux.sv
`default_nettype none
// ---------------------------------------------------------------------------
// layer_priority_mux : N-channel registered priority mux with colour key,
// per-channel enable and frame blinking; optional fade-in via LAYER_MUX_FADE_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
module layer_priority_mux #(
  parameter int         N_CH         = 3,
  parameter logic [7:0] BG_COLOR     = 8'h00,
  parameter logic [7:0] TRANSP_COLOR = 8'hFF,
  parameter int         BLINK_FRAMES = 30,
  parameter int         FADE_FRAMES  = 8
) (
  input  logic                 clk,
  input  logic                 resetN,
  layer_priority_mux_if.slave  bus
);
  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CNT_W-1:0] frame_cnt;
  logic             blink_phase;
  logic [N_CH-1:0]  valid;
  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic [7:0]       win_rgb;
  logic [7:0]       out_rgb;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (bus.startOfFrame) begin
      if (frame_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    valid = '0;
    for (int k = 0; k < N_CH; k++) begin
      valid[k] = bus.drawReq[k] & bus.layerEnable[k]
               & (bus.rgbIn[8*k +: 8] != TRANSP_COLOR)
               & (~bus.blinkMask[k] | blink_phase);
    end
  end

  // Scan from the lowest priority upward so the lowest valid index is kept last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_rgb   = BG_COLOR;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (valid[k]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(k);
        win_rgb   = bus.rgbIn[8*k +: 8];
      end
    end
  end

`ifdef LAYER_MUX_FADE_EN
  localparam int FCNT_W = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_FADING = 1'b1;

  logic [0:0]        fade_state;
  logic [1:0]        fade_level;
  logic [FCNT_W-1:0] fade_cnt;

  function automatic logic [7:0] fade_scale(input logic [7:0] p, input logic [1:0] lvl);
    return {p[7:5] >> lvl, p[4:2] >> lvl, p[1:0] >> lvl};
  endfunction

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      fade_state <= ST_IDLE;
      fade_level <= 2'd0;
      fade_cnt   <= '0;
    end else if (bus.fadeStart) begin
      fade_state <= ST_FADING;
      fade_level <= 2'd3;
      fade_cnt   <= '0;
    end else if (fade_state == ST_FADING && bus.startOfFrame) begin
      if (fade_cnt == FCNT_W'(FADE_FRAMES - 1)) begin
        fade_cnt   <= '0;
        fade_level <= fade_level - 2'd1;
        if (fade_level == 2'd1) begin
          fade_state <= ST_IDLE;
        end
      end else begin
        fade_cnt <= fade_cnt + 1'b1;
      end
    end
  end

  assign out_rgb = fade_scale(win_rgb, fade_level);
`else
  logic unused_fade;
  assign unused_fade = bus.fadeStart | (FADE_FRAMES < 1);
  assign out_rgb     = win_rgb;
`endif

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      bus.RGBOut    <= BG_COLOR;
      bus.anyDR     <= 1'b0;
      bus.winnerIdx <= '0;
    end else begin
      bus.RGBOut    <= out_rgb;
      bus.anyDR     <= win_found;
      bus.winnerIdx <= win_idx;
    end
  end
endmodule
`default_nettype wire
